// File: rtl/glitch_pkg.sv
// glitch_pkg: shared edge-select and trigger FSM encodings
package glitch_pkg;
  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_sel_e;
  typedef enum logic [1:0] {
    ST_DISARMED = 2'b00,
    ST_ARMED    = 2'b01,
    ST_HOLDOFF  = 2'b10
  } state_e;
endpackage

// File: rtl/trigger_filter.sv
// trigger_filter: synchronises the pin, rejects short glitches, emits edge strobes
module trigger_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trig_pin_i,
  input  logic [FILTER_W-1:0] filter_len_i,
  output logic                filt,
  output logic                rise,
  output logic                fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILTER_W-1:0]    cnt;
  logic                   sync;
  assign sync = sync_q[SYNC_STAGES-1];
  // filt adopts sync once it has differed for filter_len_i+1 cycles; strobes mark the update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      cnt    <= '0;
      filt   <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trig_pin_i};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (sync == filt) cnt <= '0;
      else if (cnt == filter_len_i) begin
        filt <= sync;
        rise <= sync;
        fall <= ~sync;
        cnt  <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/trigger_conditioner.sv
// trigger_conditioner: turns the filtered target trigger into a single-cycle pulser strobe
module trigger_conditioner
  import glitch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_W    = 8,
  parameter int HOLDOFF_W   = 16,
  parameter int COUNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trig_pin_i,
  input  logic [1:0]           edge_sel_i,
  input  logic [FILTER_W-1:0]  filter_len_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  input  logic                 arm_i,
  input  logic                 one_shot_i,
  input  logic                 busy_i,
  output logic                 trigger_o,
  output logic                 armed_o,
  output logic                 missed_o,
  output logic [COUNT_W-1:0]   trig_count_o
);
  state_e               state;
  logic [HOLDOFF_W-1:0] hcnt;
  logic                 filt, rise, fall, qual;
  edge_sel_e            es;
  trigger_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_W(FILTER_W)) u_filter (
    .clk         (clk),
    .rst         (rst),
    .trig_pin_i  (trig_pin_i),
    .filter_len_i(filter_len_i),
    .filt        (filt),
    .rise        (rise),
    .fall        (fall)
  );
  assign es      = edge_sel_e'(edge_sel_i);
  assign qual    = (es == EDGE_RISE) ? (rise & filt) :
                   (es == EDGE_FALL) ? (fall & ~filt) :
                   (es == EDGE_BOTH) ? ((rise & filt) | (fall & ~filt)) : 1'b0;
  assign armed_o = (state == ST_ARMED);
  // arm/one-shot/holdoff sequencing; a missed-edge set overrides a same-cycle arm clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_DISARMED;
      hcnt         <= '0;
      trigger_o    <= 1'b0;
      missed_o     <= 1'b0;
      trig_count_o <= '0;
    end else begin
      trigger_o <= 1'b0;
      if (arm_i) missed_o <= 1'b0;
      case (state)
        ST_DISARMED: if (arm_i) state <= ST_ARMED;
        ST_ARMED: if (qual && busy_i) missed_o <= 1'b1;
          else if (qual) begin
            trigger_o <= 1'b1;
            if (~&trig_count_o) trig_count_o <= trig_count_o + 1'b1;
            state <= one_shot_i ? ST_DISARMED : ST_HOLDOFF;
            hcnt  <= holdoff_i;
          end
        ST_HOLDOFF: begin
          hcnt  <= hcnt - 1'b1;
          state <= (hcnt <= HOLDOFF_W'(1)) ? ST_ARMED : ST_HOLDOFF;
        end
        default: state <= ST_DISARMED;
      endcase
    end
  end
endmodule

// File: tb/tb_trigger_conditioner.sv
// tb_trigger_conditioner: directed checks of filtering, edge select, FSM, saturation and reset
module tb_trigger_conditioner;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pin = 1'b0;
  logic [1:0]  edge_sel = 2'b00;
  logic [7:0]  filter_len = 8'd0;
  logic [15:0] holdoff = 16'd0;
  logic        arm = 1'b0, one_shot = 1'b1, busy = 1'b0;
  logic        trig, armed, missed, trig2, armed2, missed2;
  logic [7:0]  cnt;
  logic [1:0]  cnt2;
  int          checks = 0, failures = 0;
  logic        any_trig;

  always #5 clk = ~clk;

  trigger_conditioner dut (
    .clk(clk), .rst(rst), .trig_pin_i(pin), .edge_sel_i(edge_sel),
    .filter_len_i(filter_len), .holdoff_i(holdoff), .arm_i(arm),
    .one_shot_i(one_shot), .busy_i(busy), .trigger_o(trig),
    .armed_o(armed), .missed_o(missed), .trig_count_o(cnt)
  );
  trigger_conditioner #(.COUNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .trig_pin_i(pin), .edge_sel_i(edge_sel),
    .filter_len_i(filter_len), .holdoff_i(holdoff), .arm_i(arm),
    .one_shot_i(one_shot), .busy_i(busy), .trigger_o(trig2),
    .armed_o(armed2), .missed_o(missed2), .trig_count_o(cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (trig) any_trig = 1'b1;
    end
  endtask

  initial begin
    #12;
    chk("rst_trig", trig, 0);
    chk("rst_armed", armed, 0);
    chk("rst_missed", missed, 0);
    chk("rst_cnt", cnt, 0);
    rst = 1'b1;
    tick();
    do_arm();
    chk("armed_after_arm", armed, 1);
    pin = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("rise_f0_trig", trig, (i == 4));
      if (i == 4) chk("one_shot_disarm", armed, 0);
    end
    chk("cnt_1", cnt, 1);

    filter_len = 8'd4;
    pin = 1'b0;
    repeat (12) tick();
    do_arm();
    any_trig = 1'b0;
    pin = 1'b1;
    quiet(4);
    pin = 1'b0;
    quiet(12);
    chk("glitch_rejected", any_trig, 0);
    pin = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("filt4_trig", trig, (i == 8));
    end
    chk("cnt_2", cnt, 2);

    filter_len = 8'd0;
    one_shot = 1'b0;
    holdoff = 16'd10;
    edge_sel = 2'b10;
    do_arm();
    for (int i = 1; i <= 24; i++) begin
      if ((i - 1) % 6 == 0) pin = ~pin;
      tick();
      chk("holdoff_trig", trig, (i == 4 || i == 16));
    end
    chk("holdoff_no_missed", missed, 0);
    chk("cnt_4", cnt, 4);
    chk("cnt2_sat", cnt2, 3);
    repeat (3) tick();
    chk("rearmed", armed, 1);

    edge_sel = 2'b00;
    pin = 1'b0;
    repeat (6) tick();
    any_trig = 1'b0;
    busy = 1'b1;
    pin = 1'b1;
    quiet(6);
    busy = 1'b0;
    chk("busy_no_trig", any_trig, 0);
    chk("busy_missed", missed, 1);
    chk("busy_armed", armed, 1);
    do_arm();
    chk("arm_clears_missed", missed, 0);
    chk("arm_keeps_armed", armed, 1);
    pin = 1'b0;
    repeat (6) tick();
    pin = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("fifth_trig", trig, (i == 4));
    end
    chk("cnt_5", cnt, 5);
    chk("cnt2_sat5", cnt2, 3);

    edge_sel = 2'b11;
    repeat (12) tick();
    any_trig = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pin = ~pin;
      quiet(6);
    end
    chk("off_no_trig", any_trig, 0);
    chk("off_cnt", cnt, 5);
    chk("off_armed", armed, 1);

    edge_sel = 2'b10;
    pin = ~pin;
    repeat (4) tick();
    chk("pre_rst_trig", trig, 1);
    rst = 1'b0;
    #1;
    chk("rst_trunc_trig", trig, 0);
    chk("rst_armed2", armed, 0);
    chk("rst_missed2", missed, 0);
    chk("rst_cnt2", cnt, 0);
    chk("rst_cnt2_small", cnt2, 0);
    pin = 1'b1;
    edge_sel = 2'b00;
    repeat (3) tick();
    rst = 1'b1;
    any_trig = 1'b0;
    quiet(8);
    do_arm();
    quiet(8);
    chk("pin_high_release_no_trig", any_trig, 0);
    chk("pin_high_release_armed", armed, 1);
    chk("pin_high_release_cnt", cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
